mem_port_arbiter: RTL and testbench

Shares the single-port, 2-cycle-read-latency unified RAM between the instruction-fetch requester (IF) and the data requester (MEM1). Owns the grant decision, the in-flight return tagging, store byte-mask generation and fetch-starvation protection. A data access issued in MEM1 returns its word in MEM3, which is why the memory stages are split into MEM1, MEM2 and MEM3. `if_stall` and `dm_stall` feed the pipeline stall/flush logic.

---
 rtl/mem_port_arbiter_pkg.sv | 37 +++
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter_store_mask_gen.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-RAM port arbiter.
//   mem_src_t   : which requester a RAM read belongs to
//   mem_tag_t   : in-flight read tag {valid, src, half}
//   mem_size_t  : access size decoded from the funct3 width code
package mem_port_arbiter_pkg;

    localparam int MEM_READ_LAT = 2;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } mem_src_t;

    typedef struct packed {
        logic     valid;
        mem_src_t src;
        logic     half;
    } mem_tag_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_t;

    // Unsigned load codes (4..6) share the size of their signed twins.
    function automatic mem_size_t wid_to_size(input logic [2:0] wid);
        case (wid)
            3'd0, 3'd4: return SZ_B;
            3'd1, 3'd5: return SZ_H;
            3'd2, 3'd6: return SZ_W;
            default:    return SZ_D;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the memory port arbiter: the instruction-fetch
// channel (if_*) and the data channel (dm_*).
//   master : pipeline side (drives requests, receives grants/returns)
//   slave  : arbiter side
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  if_req;
    logic [DATA_WIDTH-1:0] if_addr;
    logic                  if_kill;
    logic                  if_gnt;
    logic                  if_stall;
    logic                  if_rvalid;
    logic [31:0]           if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic [DATA_WIDTH-1:0] dm_addr;
    logic [2:0]            dm_wid;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic                  dm_gnt;
    logic                  dm_stall;
    logic                  dm_rvalid;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_misalign;

    modport master (
        output if_req, if_addr, if_kill,
        output dm_req, dm_we, dm_addr, dm_wid, dm_wdata,
        input  if_gnt, if_stall, if_rvalid, if_rdata,
        input  dm_gnt, dm_stall, dm_rvalid, dm_rdata, dm_misalign
    );

    modport slave (
        input  if_req, if_addr, if_kill,
        input  dm_req, dm_we, dm_addr, dm_wid, dm_wdata,
        output if_gnt, if_stall, if_rvalid, if_rdata,
        output dm_gnt, dm_stall, dm_rvalid, dm_rdata, dm_misalign
    );
endinterface

// File: rtl/mem_port_arbiter_store_mask_gen.sv
// Combinational store lane steering for an 8-byte RAM word.
//   addr_lo  : byte offset within the word
//   wid      : funct3 width code
//   wdata    : LSB-aligned store data
//   mask     : byte write enables
//   wdata_sh : store data moved to its byte lanes
//   misalign : access crosses its natural alignment
module store_mask_gen
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            addr_lo,
    input  logic [2:0]            wid,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [7:0]            mask,
    output logic [DATA_WIDTH-1:0] wdata_sh,
    output logic                  misalign
);
    mem_size_t size;

    always_comb begin
        size     = wid_to_size(wid);
        mask     = 8'h00;
        misalign = 1'b0;
        wdata_sh = wdata << {addr_lo, 3'b000};
        case (size)
            SZ_B: mask = 8'b0000_0001 << addr_lo;
            SZ_H: begin
                mask     = 8'b0000_0011 << addr_lo;
                misalign = addr_lo[0];
            end
            SZ_W: begin
                mask     = 8'b0000_1111 << addr_lo;
                misalign = (addr_lo[1:0] != 2'b00);
            end
            default: begin
                mask     = 8'hFF;
                misalign = (addr_lo != 3'b000);
            end
        endcase
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port, fixed-latency unified RAM between
// instruction fetch and data accesses; tags reads so returns are steered
// back to their requester, and stops data from starving fetch.
//   clk, rst           : clock, synchronous active-high reset
//   bus (slave)        : fetch and data request/return channels
//   ram_en/we/addr     : RAM command
//   ram_wdata/wmask    : RAM store data and byte enables
//   ram_rdata          : RAM read data, READ_LAT cycles after the command
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int RAM_SIZE        = 16,
    parameter int READ_LAT        = MEM_READ_LAT,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [RAM_SIZE-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [7:0]            ram_wmask,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam logic [2:0] STREAK_MAX = 3'(MAX_DATA_STREAK);

    logic [2:0]            streak_q, streak_d;
    mem_tag_t              tag_q    [READ_LAT];
    mem_tag_t              tag_kept [READ_LAT];
    mem_tag_t              new_tag;
    mem_tag_t              tail;
    logic                  fetch_prio;
    logic                  dm_go;
    logic                  misalign;
    logic [7:0]            mask;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{bus.if_addr[DATA_WIDTH-1:RAM_SIZE+3], bus.if_addr[1:0],
                                bus.dm_addr[DATA_WIDTH-1:RAM_SIZE+3]};

    store_mask_gen #(.DATA_WIDTH(DATA_WIDTH)) u_store_mask_gen (
        .addr_lo  (bus.dm_addr[2:0]),
        .wid      (bus.dm_wid),
        .wdata    (bus.dm_wdata),
        .mask     (mask),
        .wdata_sh (wdata_sh),
        .misalign (misalign)
    );

    // Data normally wins; a waiting fetch takes one slot after a full streak.
    assign fetch_prio   = bus.if_req && (streak_q == STREAK_MAX);
    assign bus.dm_gnt   = bus.dm_req && !fetch_prio;
    assign bus.if_gnt   = bus.if_req && !bus.dm_gnt;
    assign bus.dm_stall = bus.dm_req && !bus.dm_gnt;
    assign bus.if_stall = bus.if_req && !bus.if_gnt;

    // A misaligned access is accepted but never reaches the RAM.
    assign dm_go           = bus.dm_gnt && !misalign;
    assign bus.dm_misalign = bus.dm_gnt && misalign;

    assign ram_en    = bus.if_gnt || dm_go;
    assign ram_we    = dm_go && bus.dm_we;
    assign ram_addr  = bus.dm_gnt ? bus.dm_addr[RAM_SIZE+2:3] : bus.if_addr[RAM_SIZE+2:3];
    assign ram_wdata = wdata_sh;
    assign ram_wmask = ram_we ? mask : 8'h00;

    always_comb begin
        new_tag.valid = (bus.if_gnt && !bus.if_kill) || (dm_go && !bus.dm_we);
        new_tag.src   = bus.dm_gnt ? SRC_DM : SRC_IF;
        new_tag.half  = bus.if_addr[2];
        for (int i = 0; i < READ_LAT; i++) begin
            tag_kept[i] = tag_q[i];
            if (bus.if_kill && tag_q[i].src == SRC_IF)
                tag_kept[i].valid = 1'b0;
        end
    end

    // The kill-filtered tail suppresses a fetch return in the kill cycle itself.
    assign tail          = tag_kept[READ_LAT-1];
    assign bus.if_rvalid = tail.valid && tail.src == SRC_IF;
    assign bus.if_rdata  = tail.half ? ram_rdata[63:32] : ram_rdata[31:0];
    assign bus.dm_rvalid = tail.valid && tail.src == SRC_DM;
    assign bus.dm_rdata  = ram_rdata;

    always_comb begin
        streak_d = streak_q;
        if (!bus.if_req || bus.if_gnt)
            streak_d = 3'd0;
        else if (bus.dm_gnt && streak_q != 3'd7)
            streak_d = streak_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= 3'd0;
            for (int i = 0; i < READ_LAT; i++)
                tag_q[i] <= '0;
        end else begin
            streak_q <= streak_d;
            tag_q[0] <= new_tag;
            for (int i = 1; i < READ_LAT; i++)
                tag_q[i] <= tag_kept[i-1];
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(64)) bus ();

    logic        ram_en, ram_we;
    logic [15:0] ram_addr;
    logic [63:0] ram_wdata, ram_rdata;
    logic [7:0]  ram_wmask;

    mem_port_arbiter #(
        .DATA_WIDTH(64), .RAM_SIZE(16), .READ_LAT(2), .MAX_DATA_STREAK(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
    );

    // RAM model: two-cycle read latency, byte-masked write at the edge.
    logic [63:0] mem [0:1023];
    logic [63:0] rd_p1, rd_p2, wr_merged;
    assign ram_rdata = rd_p2;

    always_comb begin
        wr_merged = mem[ram_addr[9:0]];
        for (int b = 0; b < 8; b++)
            if (ram_wmask[b]) wr_merged[8*b +: 8] = ram_wdata[8*b +: 8];
    end

    always @(posedge clk) begin
        if (rst) begin
            rd_p1    <= 64'h0;
            rd_p2    <= 64'h0;
            mem[1]   <= 64'h1111_2222_3333_4444;
            mem[32]  <= 64'h8000_0013_0000_0093;
        end else begin
            rd_p2 <= rd_p1;
            rd_p1 <= 64'h0;
            if (ram_en && ram_we) mem[ram_addr[9:0]] <= wr_merged;
            else if (ram_en) rd_p1 <= mem[ram_addr[9:0]];
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] exp_dm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.if_req   = 1'b0;
        bus.if_addr  = 64'h0;
        bus.if_kill  = 1'b0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 64'h0;
        bus.dm_wid   = 3'd0;
        bus.dm_wdata = 64'h0;
    endtask

    task automatic fetch(input logic [63:0] a);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
    endtask

    task automatic data(input logic we, input logic [63:0] a, input logic [2:0] wid,
                        input logic [63:0] wd);
        bus.dm_req   = 1'b1;
        bus.dm_we    = we;
        bus.dm_addr  = a;
        bus.dm_wid   = wid;
        bus.dm_wdata = wd;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        settle();
        chk("rst_if_rvalid", 64'(bus.if_rvalid), 64'd0);
        chk("rst_dm_rvalid", 64'(bus.dm_rvalid), 64'd0);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_misalign", 64'(bus.dm_misalign), 64'd0);

        // Lone fetch from the upper half of word 0x20.
        cyc(); idle(); fetch(64'h104); settle();
        chk("lf_if_gnt", 64'(bus.if_gnt), 64'd1);
        chk("lf_if_stall", 64'(bus.if_stall), 64'd0);
        chk("lf_ram_en", 64'(ram_en), 64'd1);
        chk("lf_ram_we", 64'(ram_we), 64'd0);
        chk("lf_ram_addr", 64'(ram_addr), 64'h20);
        cyc(); idle(); settle();
        chk("lf_rvalid_c1", 64'(bus.if_rvalid), 64'd0);
        cyc(); settle();
        chk("lf_rvalid_c2", 64'(bus.if_rvalid), 64'd1);
        chk("lf_rdata", 64'(bus.if_rdata), 64'h8000_0013);
        cyc(); settle();
        chk("lf_rvalid_c3", 64'(bus.if_rvalid), 64'd0);

        // sw 0xDEADBEEF @0x0C then ld @0x08.
        cyc(); idle(); data(1'b1, 64'h0C, 3'd2, 64'hDEAD_BEEF); settle();
        chk("sl_dm_gnt", 64'(bus.dm_gnt), 64'd1);
        chk("sl_ram_we", 64'(ram_we), 64'd1);
        chk("sl_wmask", 64'(ram_wmask), 64'hF0);
        chk("sl_wdata", ram_wdata, 64'hDEAD_BEEF_0000_0000);
        chk("sl_ram_addr", 64'(ram_addr), 64'h1);
        cyc(); data(1'b0, 64'h08, 3'd3, 64'h0); settle();
        chk("sl_ld_en", 64'(ram_en), 64'd1);
        chk("sl_ld_we", 64'(ram_we), 64'd0);
        cyc(); idle(); settle();
        chk("sl_st_noret", 64'(bus.dm_rvalid), 64'd0);
        cyc(); settle();
        chk("sl_ld_rvalid", 64'(bus.dm_rvalid), 64'd1);
        chk("sl_ld_rdata", bus.dm_rdata, 64'hDEAD_BEEF_3333_4444);

        // Byte-lane steering for sb and sd, and a misaligned sh.
        cyc(); idle(); data(1'b1, 64'h05, 3'd0, 64'hAB); settle();
        chk("sb_mask", 64'(ram_wmask), 64'h20);
        chk("sb_wdata", ram_wdata, 64'h0000_AB00_0000_0000);
        cyc(); idle(); data(1'b1, 64'h10, 3'd3, 64'h0123_4567_89AB_CDEF); settle();
        chk("sd_mask", 64'(ram_wmask), 64'hFF);
        chk("sd_addr", 64'(ram_addr), 64'h2);
        cyc(); idle(); data(1'b1, 64'h01, 3'd1, 64'h55AA); settle();
        chk("sh_mis_flag", 64'(bus.dm_misalign), 64'd1);
        chk("sh_mis_en", 64'(ram_en), 64'd0);
        chk("sh_mis_we", 64'(ram_we), 64'd0);

        // Starvation: both requesters held for 6 cycles, then drain.
        exp_dm = 6'b10_1111;
        cyc(); idle(); settle();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            idle();
            if (i < 6) begin
                fetch(64'h104);
                data(1'b0, 64'h08, 3'd3, 64'h0);
            end
            settle();
            if (i < 6) begin
                chk($sformatf("sv_dm_gnt_%0d", i), 64'(bus.dm_gnt), 64'(exp_dm[i]));
                chk($sformatf("sv_if_gnt_%0d", i), 64'(bus.if_gnt), 64'(!exp_dm[i]));
                chk($sformatf("sv_if_stall_%0d", i), 64'(bus.if_stall), 64'(exp_dm[i]));
            end
            if (i >= 2) begin
                chk($sformatf("sv_dm_rv_%0d", i), 64'(bus.dm_rvalid), 64'(exp_dm[i-2]));
                chk($sformatf("sv_if_rv_%0d", i), 64'(bus.if_rvalid), 64'(!exp_dm[i-2]));
            end
        end

        // Kill: fetches in cycles 0 and 1, kill in cycle 1.
        cyc(); idle(); fetch(64'h104); settle();
        chk("kl_gnt0", 64'(bus.if_gnt), 64'd1);
        cyc(); bus.if_kill = 1'b1; settle();
        chk("kl_gnt1", 64'(bus.if_gnt), 64'd1);
        cyc(); idle(); settle();
        chk("kl_rv_c2", 64'(bus.if_rvalid), 64'd0);
        cyc(); settle();
        chk("kl_rv_c3", 64'(bus.if_rvalid), 64'd0);

        // Kill arriving in the same cycle as the fetch return.
        cyc(); idle(); fetch(64'h104); settle();
        cyc(); idle();
        cyc(); bus.if_kill = 1'b1; settle();
        chk("kl_tail", 64'(bus.if_rvalid), 64'd0);
        cyc(); idle(); settle();
        chk("kl_tail_next", 64'(bus.if_rvalid), 64'd0);

        // Kill leaves a data return alone.
        cyc(); idle(); data(1'b0, 64'h08, 3'd3, 64'h0); settle();
        cyc(); idle(); bus.if_kill = 1'b1; settle();
        cyc(); idle(); settle();
        chk("kl_dm_kept", 64'(bus.dm_rvalid), 64'd1);

        // Misaligned lw @0x06.
        cyc(); idle(); data(1'b0, 64'h06, 3'd2, 64'h0); settle();
        chk("ma_gnt", 64'(bus.dm_gnt), 64'd1);
        chk("ma_flag", 64'(bus.dm_misalign), 64'd1);
        chk("ma_ram_en", 64'(ram_en), 64'd0);
        cyc(); idle(); settle();
        chk("ma_rv_c1", 64'(bus.dm_rvalid), 64'd0);
        cyc(); settle();
        chk("ma_rv_c2", 64'(bus.dm_rvalid), 64'd0);

        // Reset mid-operation with a partial streak and loads in flight.
        cyc(); idle(); fetch(64'h104); data(1'b0, 64'h08, 3'd3, 64'h0);
        cyc();
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) cyc();
            settle();
            chk($sformatf("rs_dm_gnt_%0d", j), 64'(bus.dm_gnt), 64'(j < 4));
            chk($sformatf("rs_if_gnt_%0d", j), 64'(bus.if_gnt), 64'(j == 4));
            chk($sformatf("rs_dm_rv_%0d", j), 64'(bus.dm_rvalid), 64'(j >= 2));
        end
        cyc(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
